// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory request/response bus and its responder.
package mem_responder_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } memrstate_t;

endpackage

// File: rtl/mem_responder_if.sv
// Single-outstanding request/response bus between the MMU (master) and memory (slave).
interface mem_responder_if;

  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        busy;
  logic        resp_error;

  modport master (
    output request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    input  response_enable, resp_data, busy, resp_error
  );

  modport slave (
    input  request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    output response_enable, resp_data, busy, resp_error
  );

endinterface

// File: rtl/bram_strb.sv
// Single-port read-first word RAM with byte write enables and synchronous read.
module bram_strb #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  // Read-first: rdata gets the word as it was before this edge's lane writes.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: FSM, latency counter, request latches, range check.
// Optional address range check enabled by defining MEMRESP_RANGE_CHECK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  mem_responder_if.slave  bus
);

  localparam logic [3:0] LatInit = 4'(LATENCY - 1);
  localparam bit         Direct  = (LATENCY == 1);

  memrstate_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  err_q;
  logic                  data_vld_q;
  logic                  resp_err_q;

  logic                  accept;
  logic                  access;
  logic                  req_err;
  logic                  unused_addr;
  logic                  acc_mode;
  logic                  acc_err;
  logic [3:0]            acc_wstrb;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  logic                  ram_en;
  logic [3:0]            ram_we;

`ifdef MEMRESP_RANGE_CHECK_EN
  assign req_err     = |bus.req_addr[31:ADDR_WIDTH+2];
  assign unused_addr = ^bus.req_addr[1:0];
`else
  assign req_err     = 1'b0;
  assign unused_addr = ^{bus.req_addr[31:ADDR_WIDTH+2], bus.req_addr[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.request_enable) begin
          accept = 1'b1;
          cnt_d  = LatInit;
          if (Direct) begin
            access  = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          access  = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY=1 the access happens at the accepting edge, straight from the bus.
  assign acc_mode  = Direct ? bus.req_mode                   : mode_q;
  assign acc_err   = Direct ? req_err                        : err_q;
  assign acc_wstrb = Direct ? bus.req_wstrb                  : wstrb_q;
  assign ram_addr  = Direct ? bus.req_addr[ADDR_WIDTH+1:2]   : addr_q;
  assign ram_wdata = Direct ? bus.req_wdata                  : wdata_q;

  // Gating with rstn keeps the direct path from writing while reset is held.
  assign ram_en = access & rstn;
  assign ram_we = (acc_mode == MEMREQ_WRITE && !acc_err) ? acc_wstrb : 4'b0000;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mode_q     <= MEMREQ_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      err_q      <= 1'b0;
      data_vld_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        mode_q  <= bus.req_mode;
        addr_q  <= bus.req_addr[ADDR_WIDTH+1:2];
        wdata_q <= bus.req_wdata;
        wstrb_q <= bus.req_wstrb;
        err_q   <= req_err;
      end
      if (access) begin
        data_vld_q <= 1'b1;
        resp_err_q <= acc_err;
      end
    end
  end

  bram_strb #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.response_enable = (state_q == StResp);
  assign bus.busy            = (state_q != StIdle);
  assign bus.resp_error      = resp_err_q;
  assign bus.resp_data       = (data_vld_q && !resp_err_q) ? ram_rdata : 32'h0;

endmodule
